pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Multi-channel PWM generator; successor to the single-channel fixed-parameter PWM.
- One shared period counter drives CH independent duty comparators.
- Period and per-channel duty are programmable at run time through double-buffered (staging/active) registers. Active values update only at a period boundary, so no glitched or truncated pulses occur.
- Sits between a register/config block and output pins; also drives LED dimming and motor-drive enables.

Parameters:
- CH, 4, number of PWM channels (1..16).
- N, 8, counter/period/duty width in bits (2..16).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low = counter held, outputs low.
- cfg_period  input  N  period in clock cycles; 0 = disabled.
- cfg_duty  input  CH*N  channel i duty at bits [i*N +: N], in cycles high per period.
- cfg_load  input  1  one-cycle strobe; captures cfg_period/cfg_duty into staging.
- o_pwm  output  CH  PWM outputs, registered.
- o_period_end  output  1  one-cycle pulse on the last output cycle of each period.
- o_load_pend  output  1  staging holds values not yet transferred to active.

Behaviour:
- Reset (sys_rst=1 at clock edge), all to 0:
  - cnt, staging regs, active regs (per_act, duty_act[]), load_pend.
  - o_pwm, o_period_end.
  - Block is disabled after reset until a load is applied.
- Counter, edge-aligned:
  - Runs when en=1 and per_act!=0.
  - cnt counts 0..per_act-1, then wraps to 0. "wrap" = cycle in which cnt==per_act-1 while running.
  - per_act=1 is legal: cnt stays 0 and wraps every cycle.
- Output:
  - o_pwm[i] <= running && (cnt < duty_act[i]). One-cycle latency from cnt, matching the previous generation.
  - duty_act[i]=0 gives constant low.
  - duty_act[i]>=per_act gives constant high, with no low cycle.
  - Compare is unsigned, N bits.
- o_period_end <= running && (cnt==per_act-1). It is aligned with o_pwm of the final count.
- Load:
  - cfg_load=1: staging <= cfg inputs; load_pend <= 1.
  - Transfer (active <= staging, load_pend <= 0) occurs:
    - at wrap; or
    - on any cycle where the block is not running (en=0 or per_act==0).
  - cfg_load in the same cycle as a transfer:
    - Active takes the OLD staging contents.
    - Staging takes the new inputs.
    - load_pend stays 1.
  - cfg_load in the same cycle as a wrap with load_pend=0: active is unchanged and load_pend becomes 1. The new values apply at the next wrap.
  - Repeated cfg_load before a transfer: the last write wins.
  - A period change takes effect only after the current period completes. cnt restarts at 0 in the first cycle of the new period.
- Enable:
  - en=0: cnt <= 0 and o_pwm <= 0 on the next edge; no o_period_end.
  - en 0->1: cnt starts at 0. o_pwm first reflects cnt=0 one cycle after en is sampled high.
  - en dropping mid-period abandons the period; no o_period_end is generated.
- Reset mid-operation: all state clears on the next edge regardless of en/cfg_load. A cfg_load coinciding with reset is discarded.
- o_load_pend = load_pend register, no extra latency.

Optional Feature:
- Macro: PWM_CENTER_EN.
- Defined:
  - Adds input port cfg_center (1 bit), captured into staging with cfg_load and transferred with the other fields.
  - Active centre mode:
    - Counter counts up 0..per_act-1, then down per_act-1..0. Both extremes are held for two cycles, giving a 2*per_act cycle period.
    - o_pwm[i] = cnt < duty_act[i], so high width is 2*duty_act[i] cycles, symmetric about the period boundary.
    - Wrap and o_period_end occur at cnt==0 on the down phase.
    - Direction resets to up on reset, en=0, or transfer.
- Undefined: port absent; edge-aligned only; no direction register.

Test Plan:
- Reset, load period=10, duties {0,3,10,12}, en=1:
  - ch1 high 3 of every 10 cycles.
  - ch0 always low; ch2 and ch3 always high.
  - o_period_end every 10 cycles.
- While running period=10/duty=3, cfg_load period=5/duty=2 at cnt=4:
  - Current period finishes at 10 cycles with 3 high.
  - Next period is 5 cycles with 2 high.
  - o_load_pend high from the cycle after the strobe until the transfer.
- cfg_load asserted exactly on a wrap cycle: new values apply one full period later, not immediately.
- en deasserted at cnt=6 for 4 cycles, then reasserted:
  - o_pwm low next cycle; no o_period_end.
  - Restart gives a full 3-high pulse from cnt=0.
- sys_rst asserted mid-period with load_pend=1: all outputs and o_load_pend 0 next cycle; no output activity until a new load.
- PWM_CENTER_EN, period=4, duty=1, center=1:
  - o_pwm high 2 cycles in every 8.
  - o_period_end on the final cnt=0 cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, CH duty comparators, double-buffered period/duty.
// Optional centre-aligned mode is compiled in with `define PWM_CENTER_EN (adds cfg_center).
module pwm_multi #(
    parameter int CH = 4,
    parameter int N  = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            en,
    input  logic [N-1:0]    cfg_period,
    input  logic [CH*N-1:0] cfg_duty,
`ifdef PWM_CENTER_EN
    input  logic            cfg_center,
`endif
    input  logic            cfg_load,
    output logic [CH-1:0]   o_pwm,
    output logic            o_period_end,
    output logic            o_load_pend
);

    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]    cnt_r;
    logic [N-1:0]    cnt_nxt_s;
    logic [N-1:0]    per_stg_r;
    logic [N-1:0]    per_act_r;
    logic [CH*N-1:0] duty_stg_r;
    logic [CH*N-1:0] duty_act_r;
    logic            load_pend_r;
    logic [CH-1:0]   pwm_r;
    logic [CH-1:0]   pwm_nxt_s;
    logic            period_end_r;
    logic            running_s;
    logic            last_s;
    logic            wrap_s;
    logic            xfer_s;
`ifdef PWM_CENTER_EN
    logic            center_stg_r;
    logic            center_act_r;
    logic            dir_r;
    logic            dir_nxt_s;
`endif

    // Counter sequencing, wrap detection and next-cycle output compare
    always_comb begin
        running_s = en && (per_act_r != CNT_ZERO);
        last_s    = (cnt_r == (per_act_r - CNT_ONE));
        wrap_s    = 1'b0;
        cnt_nxt_s = CNT_ZERO;
`ifdef PWM_CENTER_EN
        dir_nxt_s = 1'b0;
`endif
        if (!running_s) begin
            cnt_nxt_s = CNT_ZERO;
        end
`ifdef PWM_CENTER_EN
        // Centre mode holds each extreme for two cycles by flipping direction without stepping
        else if (center_act_r) begin
            if (!dir_r) begin
                if (last_s) begin
                    cnt_nxt_s = cnt_r;
                    dir_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    dir_nxt_s = 1'b0;
                end
            end else begin
                if (cnt_r == CNT_ZERO) begin
                    wrap_s    = 1'b1;
                    cnt_nxt_s = CNT_ZERO;
                    dir_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    dir_nxt_s = 1'b1;
                end
            end
        end
`endif
        else begin
            if (last_s) begin
                wrap_s    = 1'b1;
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end
        // Idle cycles transfer too, so a stopped block picks up new settings immediately
        xfer_s = wrap_s || !running_s;
        for (int i = 0; i < CH; i++) begin
            pwm_nxt_s[i] = running_s && (cnt_r < duty_act_r[i*N +: N]);
        end
    end

    // State registers: counter, staging/active banks, registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r        <= CNT_ZERO;
            per_stg_r    <= CNT_ZERO;
            per_act_r    <= CNT_ZERO;
            duty_stg_r   <= {(CH*N){1'b0}};
            duty_act_r   <= {(CH*N){1'b0}};
            load_pend_r  <= 1'b0;
            pwm_r        <= {CH{1'b0}};
            period_end_r <= 1'b0;
`ifdef PWM_CENTER_EN
            center_stg_r <= 1'b0;
            center_act_r <= 1'b0;
            dir_r        <= 1'b0;
`endif
        end else begin
            cnt_r        <= cnt_nxt_s;
            pwm_r        <= pwm_nxt_s;
            period_end_r <= wrap_s;
            if (xfer_s) begin
                per_act_r  <= per_stg_r;
                duty_act_r <= duty_stg_r;
            end
            // A load coinciding with a transfer keeps the pending flag: active got the old staging
            if (cfg_load) begin
                per_stg_r   <= cfg_period;
                duty_stg_r  <= cfg_duty;
                load_pend_r <= 1'b1;
            end else if (xfer_s) begin
                load_pend_r <= 1'b0;
            end
`ifdef PWM_CENTER_EN
            dir_r <= xfer_s ? 1'b0 : dir_nxt_s;
            if (xfer_s) begin
                center_act_r <= center_stg_r;
            end
            if (cfg_load) begin
                center_stg_r <= cfg_center;
            end
`endif
        end
    end

    assign o_pwm        = pwm_r;
    assign o_period_end = period_end_r;
    assign o_load_pend  = load_pend_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (CH=4, N=8): fixed vector table, test-plan sequences, then random stimulus
// against a period-position reference model.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int N  = 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            en = 1'b0;
    logic [N-1:0]    cfg_period = 8'd0;
    logic [CH*N-1:0] cfg_duty = 32'd0;
    logic            cfg_center = 1'b0;
    logic            cfg_load = 1'b0;
    logic [CH-1:0]   o_pwm;
    logic            o_period_end;
    logic            o_load_pend;

    int total = 0;
    int bad = 0;

    pwm_multi #(.CH(CH), .N(N)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
`ifdef PWM_CENTER_EN
        .cfg_center  (cfg_center),
`endif
        .cfg_load    (cfg_load),
        .o_pwm       (o_pwm),
        .o_period_end(o_period_end),
        .o_load_pend (o_load_pend)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: position within the period, staging/active copies as plain ints
    int m_pa, m_ps, m_pos;
    int m_da[CH];
    int m_ds[CH];
    bit m_ca, m_cs, m_pend;
    logic [CH-1:0] exp_pwm;
    logic          exp_end;

    task automatic model_step();
        bit run, wrap;
        int len, v;
        if (sys_rst) begin
            m_pa = 0; m_ps = 0; m_pos = 0; m_ca = 0; m_cs = 0; m_pend = 0;
            for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
            exp_pwm = 4'b0000;
            exp_end = 1'b0;
        end else begin
            run  = en && (m_pa != 0);
            len  = m_ca ? 2 * m_pa : m_pa;
            v    = (m_ca && m_pos >= m_pa) ? (2 * m_pa - 1 - m_pos) : m_pos;
            for (int i = 0; i < CH; i++) exp_pwm[i] = run && (v < m_da[i]);
            wrap    = run && (m_pos == len - 1);
            exp_end = wrap;
            m_pos   = (run && !wrap) ? m_pos + 1 : 0;
            if (wrap || !run) begin
                m_pa = m_ps; m_ca = m_cs;
                for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
            end
            if (cfg_load) begin
                m_ps = int'(cfg_period);
                m_cs = cfg_center;
                for (int i = 0; i < CH; i++) m_ds[i] = int'(cfg_duty[i*N +: N]);
                m_pend = 1;
            end else if (wrap || !run) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock: model follows the same sampled inputs, outputs read 1 time unit after the edge
    task automatic cyc();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        rst, en, ld;
        logic [7:0]  per;
        logic [31:0] duty;
        logic [3:0]  pwm;
        logic        pe, pd;
    } vec_t;

    vec_t tbl[23];
    int   cnt_hi[CH];
    int   cnt_end;

    initial begin
        // period 4, duties {0,1,4,5}, then reloads to (2,1), (3,2), (5,4) and reset
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'd4, 32'h05040100, 4'b0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1110, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1100, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1100, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1100, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1110, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1110, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'd2, 32'h01010101, 4'b1100, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1100, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1100, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1111, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 8'd3, 32'h02020202, 4'b1111, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 8'd5, 32'h04040404, 4'b0000, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1111, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1111, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b1111, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 8'd7, 32'h07070707, 4'b0000, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'b0000, 1'b0, 1'b0};

        for (int k = 0; k < 23; k++) begin
            sys_rst = tbl[k].rst; en = tbl[k].en; cfg_load = tbl[k].ld;
            cfg_period = tbl[k].per; cfg_duty = tbl[k].duty;
            cyc();
            chk($sformatf("tbl%0d_pwm", k), 32'(o_pwm), 32'(tbl[k].pwm));
            chk($sformatf("tbl%0d_end", k), 32'(o_period_end), 32'(tbl[k].pe));
            chk($sformatf("tbl%0d_pend", k), 32'(o_load_pend), 32'(tbl[k].pd));
        end

        // Period 10, duties {0,3,10,12}: count activity over two full periods
        sys_rst = 1'b1; cfg_load = 1'b0; en = 1'b0; cyc();
        sys_rst = 1'b0; en = 1'b1; cfg_load = 1'b1;
        cfg_period = 8'd10; cfg_duty = {8'd12, 8'd10, 8'd3, 8'd0};
        cyc();
        cfg_load = 1'b0; cyc();
        for (int i = 0; i < CH; i++) cnt_hi[i] = 0;
        cnt_end = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            for (int i = 0; i < CH; i++) cnt_hi[i] += int'(o_pwm[i]);
            cnt_end += int'(o_period_end);
        end
        chk("p10_ch0_hi", 32'(cnt_hi[0]), 32'd0);
        chk("p10_ch1_hi", 32'(cnt_hi[1]), 32'd6);
        chk("p10_ch2_hi", 32'(cnt_hi[2]), 32'd20);
        chk("p10_ch3_hi", 32'(cnt_hi[3]), 32'd20);
        chk("p10_ends", 32'(cnt_end), 32'd2);

        // Drop en at cnt=6 for 4 cycles: outputs low at once, no period end, full restart
        for (int c = 0; c < 6; c++) cyc();
        en = 1'b0; cyc();
        chk("en_off_pwm", 32'(o_pwm), 32'd0);
        chk("en_off_end", 32'(o_period_end), 32'd0);
        for (int c = 0; c < 3; c++) cyc();
        en = 1'b1;
        cnt_hi[1] = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            cnt_hi[1] += int'(o_pwm[1]);
            if (c < 3) chk($sformatf("restart_ch1_c%0d", c), 32'(o_pwm[1]), 32'd1);
        end
        chk("restart_ch1_total", 32'(cnt_hi[1]), 32'd3);
        chk("restart_end", 32'(o_period_end), 32'd1);

`ifdef PWM_CENTER_EN
        // Centre mode, period 4, duty 1: high 2 of every 8, period end on final cnt=0
        sys_rst = 1'b1; cyc();
        sys_rst = 1'b0; en = 1'b1; cfg_load = 1'b1; cfg_center = 1'b1;
        cfg_period = 8'd4; cfg_duty = 32'h01010101;
        cyc();
        cfg_load = 1'b0; cfg_center = 1'b0; cyc();
        cnt_hi[0] = 0; cnt_end = 0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            cnt_hi[0] += int'(o_pwm[0]);
            cnt_end += int'(o_period_end);
            if (c == 7) chk("ctr_end_pos", 32'(o_period_end), 32'd1);
        end
        chk("ctr_hi", 32'(cnt_hi[0]), 32'd4);
        chk("ctr_ends", 32'(cnt_end), 32'd2);
`endif

        // Random stimulus against the reference model
        sys_rst = 1'b1; cfg_load = 1'b0; cyc();
        sys_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            sys_rst  = ($urandom_range(0, 299) == 0);
            en       = ($urandom_range(0, 24) != 0);
            cfg_load = ($urandom_range(0, 11) == 0);
            cfg_period = 8'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) cfg_duty[i*N +: N] = 8'($urandom_range(0, 14));
`ifdef PWM_CENTER_EN
            cfg_center = 1'($urandom_range(0, 1));
`endif
            cyc();
            chk("rnd_pwm", 32'(o_pwm), 32'(exp_pwm));
            chk("rnd_end", 32'(o_period_end), 32'(exp_end));
            chk("rnd_pend", 32'(o_load_pend), 32'(m_pend));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
